mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the 32-byte data memory of the 8-bit CPU.
- Shares the single memory port between requester 0 (CPU load/store unit) and requester 1 (debug/DMA loader), using round-robin.
- Drives the memory's address, write-data, read-strobe and write-strobe, and returns read data through a per-requester acknowledge handshake.

Parameters:
- DEPTH, 32: number of valid memory locations; addresses >= DEPTH are rejected.
- AW, 8: address width.
- DW, 8: data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0  in  1  requester 0 access request.
- we0  in  1  requester 0 write enable (1 = write, 0 = read).
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- ack0  out  1  requester 0 completion pulse.
- rdata0  out  DW  requester 0 read data, valid while ack0 = 1.
- err0  out  1  requester 0 out-of-range flag, valid while ack0 = 1.
- req1, we1, addr1, wdata1, ack1, rdata1, err1: same definitions, for requester 1.
- mem_address  out  AW  memory address.
- mem_write_data  out  DW  memory write data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_read_data  in  DW  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 1 (so requester 0 wins the first tie).
- Reset is asynchronous and may assert mid-operation: state returns to IDLE, mem_write and mem_read drop immediately, no write is committed, no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples req0/req1 on each rising edge.
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_grant.
  - On grant: latch we, addr, wdata and the port id into internal registers; update last_grant; go to ACCESS.
  - No request: stay in IDLE.
  - mem_read and mem_write are 0 throughout IDLE.
- ACCESS (exactly one cycle):
  - mem_address and mem_write_data driven from the latched values.
  - mem_write = latched we; mem_read = not latched we.
  - Out-of-range (latched addr >= DEPTH): both strobes held at 0 and the error bit is latched.
  - The memory commits a write at the edge that leaves ACCESS.
  - At that same edge, mem_read_data is captured into the granted port's rdata register.
  - Next state: RESP.
- RESP (exactly one cycle):
  - Granted port's ack = 1; its rdata and err are valid.
  - Read data on a write transaction: rdata = 0.
  - Out-of-range transaction: err = 1 and rdata = 0.
  - Both strobes are 0. This is mandatory: the memory's read is level-triggered on mem_read, so mem_read must fall between consecutive reads for each read to resample.
  - Next state: IDLE.
- Latency: req sampled at edge E0 → ACCESS in cycle E0..E1 → ack high in cycle E1..E2. Peak throughput is one access per 3 cycles.
- Handshake rules:
  - A requester holds req, we, addr and wdata stable until its ack.
  - The arbiter uses only latched values after the grant edge.
  - If req drops after the grant, the transaction still completes and ack still pulses.
  - A requester that keeps req high after ack is treated as a new request in IDLE and competes via round-robin, so neither port can starve the other.
- ack0 and ack1 are never high in the same cycle; each ack is high for exactly one cycle.
- mem_address and mem_write_data hold their last values outside ACCESS.
- Width rules: address compare is unsigned, AW bits; no wrap-around. Address 32 is an error, not an alias of address 0.

Test Plan:
- Read via port 0 after reset: req0 = 1, we0 = 0, addr0 = 5 → mem_read high for exactly 1 cycle; ack0 pulses 2 cycles after the sampling edge with rdata0 = 0x05, err0 = 0.
- Write then read back via port 1: write addr1 = 17, wdata1 = 0xA5 (memory initially 0xFF), then read addr1 = 17 → second ack1 returns rdata1 = 0xA5; mem_write high for only 1 cycle.
- Contention: req0 and req1 both held high for 4 transactions (port 0 reads addr 3, port 1 reads addr 20) → grants alternate 0,1,0,1; rdata0 = 0x03, rdata1 = 0xFC; acks are never simultaneous.
- Back-to-back reads on port 0: addr 2 then addr 9 → mem_read returns low in RESP/IDLE between the two accesses; rdata0 = 0x02 then 0x09.
- Out of range: port 0 writes addr0 = 40 → no mem_write pulse; ack0 with err0 = 1; memory locations 8 and 0 unchanged (read back 0x08 and 0x00).
- Reset mid-operation: assert rst during the ACCESS cycle of a write to addr 4 (data 0x77) → mem_write drops immediately, no ack; a subsequent read of addr 4 returns 0x04; busy = 0 after reset.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Two-requester memory access bus plus the shared memory port it arbitrates.
interface mem_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic          ack0;
   logic [DW-1:0] rdata0;
   logic          err0;

   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic          ack1;
   logic [DW-1:0] rdata1;
   logic          err1;

   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_write_data;
   logic          mem_read;
   logic          mem_write;
   logic [DW-1:0] mem_read_data;
   logic          busy;

   // Arbiter side
   modport slave (
      input  req0, we0, addr0, wdata0,
      output ack0, rdata0, err0,
      input  req1, we1, addr1, wdata1,
      output ack1, rdata1, err1,
      output mem_address, mem_write_data, mem_read, mem_write, busy,
      input  mem_read_data
   );

   // Requester/memory side
   modport master (
      output req0, we0, addr0, wdata0,
      input  ack0, rdata0, err0,
      output req1, we1, addr1, wdata1,
      input  ack1, rdata1, err1,
      input  mem_address, mem_write_data, mem_read, mem_write, busy,
      output mem_read_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one data-memory port between the CPU
// load/store unit (port 0) and the debug/DMA loader (port 1).
//
// state  | meaning
// IDLE   | waiting for a request; strobes low
// ACCESS | one cycle with the memory strobe asserted from latched request
// RESP   | one cycle ack to the granted port with rdata/err; strobes low
module mem_arbiter #(
   parameter int DEPTH = 32,
   parameter int AW    = 8,
   parameter int DW    = 8
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   // One extra bit so a DEPTH equal to 2**AW still compares correctly.
   localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

   state_t        state;
   logic          last_grant;
   logic          lat_port;
   logic          lat_we;
   logic          lat_err;

   logic          gnt_valid;
   logic          gnt_port;
   logic          gnt_we;
   logic [AW-1:0] gnt_addr;
   logic [DW-1:0] gnt_wdata;
   logic          gnt_in_range;

   // Pick the winning requester: a lone request wins, a tie goes to the port
   // that did not win last time.
   always_comb begin
      gnt_valid = bus.req0 | bus.req1;
      gnt_port  = 1'b0;
      if (bus.req0 && bus.req1)
         gnt_port = ~last_grant;
      else if (bus.req1)
         gnt_port = 1'b1;
      gnt_we       = gnt_port ? bus.we1    : bus.we0;
      gnt_addr     = gnt_port ? bus.addr1  : bus.addr0;
      gnt_wdata    = gnt_port ? bus.wdata1 : bus.wdata0;
      gnt_in_range = {1'b0, gnt_addr} < LIMIT;
   end

   // Sequencer: strobes are registered at the grant edge so they are high
   // exactly for the ACCESS cycle and drop asynchronously on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         last_grant         <= 1'b1;
         lat_port           <= 1'b0;
         lat_we             <= 1'b0;
         lat_err            <= 1'b0;
         bus.ack0           <= 1'b0;
         bus.rdata0         <= '0;
         bus.err0           <= 1'b0;
         bus.ack1           <= 1'b0;
         bus.rdata1         <= '0;
         bus.err1           <= 1'b0;
         bus.mem_address    <= '0;
         bus.mem_write_data <= '0;
         bus.mem_read       <= 1'b0;
         bus.mem_write      <= 1'b0;
         bus.busy           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_valid) begin
                  state              <= ACCESS;
                  busy_set();
                  last_grant         <= gnt_port;
                  lat_port           <= gnt_port;
                  lat_we             <= gnt_we;
                  lat_err            <= ~gnt_in_range;
                  bus.mem_address    <= gnt_addr;
                  bus.mem_write_data <= gnt_wdata;
                  bus.mem_read       <= gnt_in_range & ~gnt_we;
                  bus.mem_write      <= gnt_in_range & gnt_we;
               end
            end
            ACCESS: begin
               state         <= RESP;
               bus.mem_read  <= 1'b0;
               bus.mem_write <= 1'b0;
               if (lat_port) begin
                  bus.ack1   <= 1'b1;
                  bus.err1   <= lat_err;
                  bus.rdata1 <= (lat_we || lat_err) ? '0 : bus.mem_read_data;
               end else begin
                  bus.ack0   <= 1'b1;
                  bus.err0   <= lat_err;
                  bus.rdata0 <= (lat_we || lat_err) ? '0 : bus.mem_read_data;
               end
            end
            RESP: begin
               state      <= IDLE;
               bus.busy   <= 1'b0;
               bus.ack0   <= 1'b0;
               bus.rdata0 <= '0;
               bus.err0   <= 1'b0;
               bus.ack1   <= 1'b0;
               bus.rdata1 <= '0;
               bus.err1   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Kept as a tiny helper so the grant branch reads as a list of latches.
   task automatic busy_set();
      bus.busy <= 1'b1;
   endtask
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 32-byte memory model.
// Initial memory: mem[i] = i for i < 16, mem[i] = 0x110 - i (mod 256) above.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_init = 1'b1;
   int   tests = 0;
   int   fails = 0;

   logic [7:0] mem [32];

   mem_arbiter_if #(.AW(8), .DW(8)) mif ();

   mem_arbiter #(.DEPTH(32), .AW(8), .DW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (mif.slave)
   );

   always #5 clk = ~clk;

   // Memory model: commits on the edge that ends a mem_write cycle, level read.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++)
            mem[i] <= (i < 16) ? 8'(i) : 8'(272 - i);
      end else if (mif.mem_write) begin
         mem[mif.mem_address[4:0]] <= mif.mem_write_data;
      end
   end

   assign mif.mem_read_data = mif.mem_read ? mem[mif.mem_address[4:0]] : 8'h00;

   // Issue one request on a port and wait (bounded) for its ack.
   task automatic do_access(input bit port, input bit w, input logic [7:0] a,
                            input logic [7:0] d, output logic [7:0] rd,
                            output logic e, output int lat, output int rdc,
                            output int wrc, output bit other_ack);
      bit got;
      @(negedge clk);
      if (port) begin
         mif.req1 = 1'b1; mif.we1 = w; mif.addr1 = a; mif.wdata1 = d;
      end else begin
         mif.req0 = 1'b1; mif.we0 = w; mif.addr0 = a; mif.wdata0 = d;
      end
      got = 0; lat = -1; rdc = 0; wrc = 0; other_ack = 0; rd = '0; e = 1'b0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge clk);
         if (mif.mem_read)  rdc++;
         if (mif.mem_write) wrc++;
         if (port ? mif.ack0 : mif.ack1) other_ack = 1;
         if (port ? mif.ack1 : mif.ack0) begin
            got = 1;
            lat = i;
            rd  = port ? mif.rdata1 : mif.rdata0;
            e   = port ? mif.err1 : mif.err0;
         end
      end
      mif.req0 = 1'b0;
      mif.req1 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_init = 1'b1;
      mif.req0 = 0; mif.we0 = 0; mif.addr0 = 0; mif.wdata0 = 0;
      mif.req1 = 0; mif.we1 = 0; mif.addr1 = 0; mif.wdata1 = 0;
      repeat (3) @(negedge clk);
      mem_init = 1'b0;
      tests++;
      if ({mif.ack0, mif.ack1, mif.err0, mif.err1, mif.mem_read, mif.mem_write, mif.busy} !== 7'b0) begin
         fails++;
         $display("FAIL reset_flags: got %b, expected 0000000",
                  {mif.ack0, mif.ack1, mif.err0, mif.err1, mif.mem_read, mif.mem_write, mif.busy});
      end
      tests++;
      if ({mif.rdata0, mif.rdata1, mif.mem_address, mif.mem_write_data} !== 32'h0) begin
         fails++;
         $display("FAIL reset_buses: got %h, expected 00000000",
                  {mif.rdata0, mif.rdata1, mif.mem_address, mif.mem_write_data});
      end
      rst = 1'b0;
   endtask

   task automatic test_read_port0();
      logic [7:0] rd; logic e; int lat, rdc, wrc; bit oth;
      do_access(0, 0, 8'd5, 8'h00, rd, e, lat, rdc, wrc, oth);
      tests++;
      if (lat !== 2) begin fails++; $display("FAIL rd0_latency: got %0d, expected 2", lat); end
      tests++;
      if (rd !== 8'h05 || e !== 1'b0) begin
         fails++; $display("FAIL rd0_data: got %h err %b, expected 05 err 0", rd, e);
      end
      tests++;
      if (rdc !== 1 || wrc !== 0 || oth) begin
         fails++; $display("FAIL rd0_strobes: rd %0d wr %0d other_ack %0d, expected 1 0 0", rdc, wrc, oth);
      end
   endtask

   task automatic test_write_read_port1();
      logic [7:0] rd; logic e; int lat, rdc, wrc; bit oth;
      do_access(1, 1, 8'd17, 8'hA5, rd, e, lat, rdc, wrc, oth);
      tests++;
      if (lat !== 2 || rd !== 8'h00 || e !== 1'b0) begin
         fails++; $display("FAIL wr1_ack: lat %0d rdata %h err %b, expected 2 00 0", lat, rd, e);
      end
      tests++;
      if (wrc !== 1 || rdc !== 0 || oth) begin
         fails++; $display("FAIL wr1_strobes: wr %0d rd %0d other_ack %0d, expected 1 0 0", wrc, rdc, oth);
      end
      do_access(1, 0, 8'd17, 8'h00, rd, e, lat, rdc, wrc, oth);
      tests++;
      if (lat !== 2 || rd !== 8'hA5 || e !== 1'b0) begin
         fails++; $display("FAIL rd1_back: lat %0d rdata %h err %b, expected 2 a5 0", lat, rd, e);
      end
   endtask

   task automatic test_contention();
      int n = 0;
      bit both = 0;
      logic [3:0] order = '0;
      @(negedge clk);
      mif.req0 = 1; mif.we0 = 0; mif.addr0 = 8'd3;
      mif.req1 = 1; mif.we1 = 0; mif.addr1 = 8'd20;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clk);
         if (mif.ack0 && mif.ack1) both = 1;
         if (mif.ack0) begin
            tests++;
            if (mif.rdata0 !== 8'h03) begin
               fails++; $display("FAIL cont_rdata0: got %h, expected 03", mif.rdata0);
            end
            order[n] = 1'b0; n++;
         end else if (mif.ack1) begin
            tests++;
            if (mif.rdata1 !== 8'hFC) begin
               fails++; $display("FAIL cont_rdata1: got %h, expected fc", mif.rdata1);
            end
            order[n] = 1'b1; n++;
         end
      end
      mif.req0 = 0; mif.req1 = 0;
      tests++;
      if (n !== 4) begin fails++; $display("FAIL cont_count: got %0d acks, expected 4", n); end
      tests++;
      if (order !== 4'b1010) begin
         fails++; $display("FAIL cont_order: got %b (bit0 first), expected 1010", order);
      end
      tests++;
      if (both) begin fails++; $display("FAIL cont_simul_ack: got 1, expected 0"); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd; logic e; int lat, rdc, wrc; bit oth;
      do_access(0, 0, 8'd2, 8'h00, rd, e, lat, rdc, wrc, oth);
      tests++;
      if (rd !== 8'h02 || rdc !== 1 || mif.mem_read !== 1'b0) begin
         fails++; $display("FAIL b2b_first: rdata %h rd_cycles %0d mem_read_in_resp %b, expected 02 1 0",
                           rd, rdc, mif.mem_read);
      end
      do_access(0, 0, 8'd9, 8'h00, rd, e, lat, rdc, wrc, oth);
      tests++;
      if (rd !== 8'h09 || rdc !== 1 || lat !== 2) begin
         fails++; $display("FAIL b2b_second: rdata %h rd_cycles %0d lat %0d, expected 09 1 2", rd, rdc, lat);
      end
   endtask

   task automatic test_out_of_range();
      logic [7:0] rd; logic e; int lat, rdc, wrc; bit oth;
      do_access(0, 1, 8'd40, 8'h5A, rd, e, lat, rdc, wrc, oth);
      tests++;
      if (lat !== 2 || e !== 1'b1 || rd !== 8'h00 || wrc !== 0 || rdc !== 0) begin
         fails++; $display("FAIL oor_write: lat %0d err %b rdata %h wr %0d rd %0d, expected 2 1 00 0 0",
                           lat, e, rd, wrc, rdc);
      end
      do_access(0, 0, 8'd8, 8'h00, rd, e, lat, rdc, wrc, oth);
      tests++;
      if (rd !== 8'h08 || e !== 1'b0) begin
         fails++; $display("FAIL oor_mem8: got %h err %b, expected 08 0", rd, e);
      end
      do_access(0, 0, 8'd0, 8'h00, rd, e, lat, rdc, wrc, oth);
      tests++;
      if (rd !== 8'h00 || e !== 1'b0) begin
         fails++; $display("FAIL oor_mem0: got %h err %b, expected 00 0", rd, e);
      end
      do_access(1, 0, 8'd32, 8'h00, rd, e, lat, rdc, wrc, oth);
      tests++;
      if (e !== 1'b1 || rd !== 8'h00 || rdc !== 0) begin
         fails++; $display("FAIL oor_addr32: err %b rdata %h rd %0d, expected 1 00 0", e, rd, rdc);
      end
      do_access(1, 0, 8'd31, 8'h00, rd, e, lat, rdc, wrc, oth);
      tests++;
      if (e !== 1'b0 || rd !== 8'hF1) begin
         fails++; $display("FAIL oor_addr31: err %b rdata %h, expected 0 f1", e, rd);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [7:0] rd; logic e; int lat, rdc, wrc; bit oth;
      bit saw_ack = 0;
      @(negedge clk);
      mif.req0 = 1; mif.we0 = 1; mif.addr0 = 8'd4; mif.wdata0 = 8'h77;
      @(posedge clk);
      #1;
      tests++;
      if (mif.mem_write !== 1'b1) begin
         fails++; $display("FAIL midrst_access: mem_write %b, expected 1", mif.mem_write);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if (mif.mem_write !== 1'b0 || mif.mem_read !== 1'b0 || mif.busy !== 1'b0) begin
         fails++; $display("FAIL midrst_drop: wr %b rd %b busy %b, expected 0 0 0",
                           mif.mem_write, mif.mem_read, mif.busy);
      end
      mif.req0 = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (mif.ack0 || mif.ack1) saw_ack = 1;
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (mif.ack0 || mif.ack1) saw_ack = 1;
      end
      tests++;
      if (saw_ack) begin fails++; $display("FAIL midrst_ack: got ack, expected none"); end
      tests++;
      if (mem[4] !== 8'h04) begin
         fails++; $display("FAIL midrst_model: mem[4] %h, expected 04", mem[4]);
      end
      do_access(0, 0, 8'd4, 8'h00, rd, e, lat, rdc, wrc, oth);
      tests++;
      if (rd !== 8'h04 || e !== 1'b0 || lat !== 2) begin
         fails++; $display("FAIL midrst_readback: rdata %h err %b lat %0d, expected 04 0 2", rd, e, lat);
      end
   endtask

   initial begin
      test_reset();
      test_read_port0();
      test_write_read_port1();
      test_contention();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_op();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
